// File: rtl/ld16_seq.sv
// ld16_seq: M-cycle/T-cycle sequencer for LD rr,nn / LD SP,HL / LD (nn),SP
module ld16_seq #(
  parameter int T_PER_M = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] opcode,
  output logic       busy,
  output logic [2:0] mcyc,
  output logic [1:0] tcyc,
  output logic [1:0] adr_sel,
  output logic       rd,
  output logic       wr,
  output logic       dout_hi,
  output logic       z_we,
  output logic       w_we,
  output logic       wz_inc,
  output logic       pc_inc,
  output logic       rr_we,
  output logic [1:0] rr_sel,
  output logic       sp_from_hl,
  output logic       done,
  output logic       illegal
);
  typedef enum logic [1:0] {K_IDLE, K_LD, K_SPHL, K_ST} kind_e;
  localparam logic [1:0] T_LAST = 2'(T_PER_M - 1);
  kind_e kind_q, kind_d, op_kind;
  logic [2:0] mcyc_q, mcyc_d;
  logic [1:0] tcyc_q, tcyc_d, rr_sel_q, rr_sel_d;
  logic illegal_q, illegal_d, acc, fetch, t_last;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kind_q    <= K_IDLE;
      mcyc_q    <= 3'd0;
      tcyc_q    <= 2'd0;
      rr_sel_q  <= 2'd0;
      illegal_q <= 1'b0;
    end else begin
      kind_q    <= kind_d;
      mcyc_q    <= mcyc_d;
      tcyc_q    <= tcyc_d;
      rr_sel_q  <= rr_sel_d;
      illegal_q <= illegal_d;
    end
  end
  always_comb begin
    t_last     = tcyc_q == T_LAST;
    fetch      = (kind_q == K_LD || kind_q == K_ST) && mcyc_q <= 3'd3;
    busy       = kind_q != K_IDLE;
    mcyc       = mcyc_q;
    tcyc       = tcyc_q;
    rr_sel     = rr_sel_q;
    illegal    = illegal_q;
    rd         = fetch;
    z_we       = fetch && mcyc_q == 3'd2 && tcyc_q == 2'd2;
    w_we       = fetch && mcyc_q == 3'd3 && tcyc_q == 2'd2;
    pc_inc     = fetch && t_last;
    rr_we      = kind_q == K_LD && mcyc_q == 3'd3 && t_last;
    sp_from_hl = kind_q == K_SPHL && t_last;
    wr         = kind_q == K_ST && mcyc_q >= 3'd4 && tcyc_q != 2'd0;
    dout_hi    = kind_q == K_ST && mcyc_q == 3'd5;
    wz_inc     = kind_q == K_ST && mcyc_q == 3'd4 && t_last;
    adr_sel    = kind_q == K_SPHL ? 2'd2 : kind_q == K_ST && mcyc_q >= 3'd4 ? 2'd3 : 2'd0;
    done       = t_last && (kind_q == K_LD && mcyc_q == 3'd3 || kind_q == K_SPHL && mcyc_q == 3'd2 || kind_q == K_ST && mcyc_q == 3'd5);
  end
  always_comb begin
    op_kind   = (opcode & 8'hCF) == 8'h01 ? K_LD : opcode == 8'hF9 ? K_SPHL : opcode == 8'h08 ? K_ST : K_IDLE;
    acc       = start && (kind_q == K_IDLE || done);
    kind_d    = acc ? op_kind : done ? K_IDLE : kind_q;
    mcyc_d    = acc ? (op_kind == K_IDLE ? 3'd0 : 3'd2) : done || kind_q == K_IDLE ? 3'd0 : mcyc_q + {2'b00, t_last};
    tcyc_d    = acc || done || kind_q == K_IDLE ? 2'd0 : tcyc_q + 2'd1;
    rr_sel_d  = acc && op_kind != K_IDLE ? opcode[5:4] : rr_sel_q;
    illegal_d = acc && op_kind == K_IDLE;
  end
endmodule

// File: doc/ld16_seq.md
Name: ld16_seq

Overview:
- M-cycle/T-cycle sequencer for the 16-bit load group of the SM83-compatible CPU core.
- The decoder hands it an opcode fetched in M1. The block then drives address select, memory strobes, PC increment and register-file write enables until the instruction completes, and signals when the next M1 fetch may start.
- Covers LD rr,nn, LD SP,HL and LD (nn),SP.
- Sits between the decoder and the register file / address unit.

Parameters:
- T_PER_M, 4, T-states per M-cycle (the fixed counter width is 2 bits; only 4 is supported).

Ports:
- clk  input  1  core clock; one T-state per cycle
- reset_n  input  1  synchronous active-low reset
- start  input  1  decoder strobe, valid at M1T4 of the opcode fetch
- opcode  input  8  opcode byte, sampled with start
- busy  output  1  sequence in progress
- mcyc  output  3  current M-cycle number, 2..5 while busy, 0 when idle
- tcyc  output  2  current T-state, 0..3 = T1..T4
- adr_sel  output  2  address source: 0=PC, 1=SP, 2=HL, 3=WZ
- rd  output  1  memory read request
- wr  output  1  memory write request
- dout_hi  output  1  write data select: 0=SP[7:0], 1=SP[15:8]
- z_we  output  1  latch din into Z
- w_we  output  1  latch din into W
- wz_inc  output  1  increment WZ
- pc_inc  output  1  increment PC
- rr_we  output  1  write WZ into pair rr_sel
- rr_sel  output  2  pair: 0=BC, 1=DE, 2=HL, 3=SP
- sp_from_hl  output  1  write HL into SP
- done  output  1  last T-state of the instruction; the next cycle is M1T1 of the next fetch
- illegal  output  1  one-cycle pulse when start arrives with an unsupported opcode

Behaviour:
- All outputs are a function of the registered state only (Moore).
- Reset: busy=0, mcyc=0, tcyc=0, adr_sel=0, and every strobe (rd, wr, dout_hi, z_we, w_we, wz_inc, pc_inc, rr_we, sp_from_hl, done, illegal) is 0. rr_sel=0.
- Reset asserted mid-sequence aborts the sequence: the idle state is reached on the next edge, and no further register write or memory strobe follows.
- States: IDLE, RUN(kind, mcyc, tcyc).
- Kinds, chosen at start when not busy:
  - LOAD_IMM: opcode & 0xCF == 0x01.
  - SP_HL: opcode == 0xF9.
  - STORE_SP: opcode == 0x08.
- rr_sel = opcode[5:4], latched at start.
- Any other opcode: illegal=1 for exactly one cycle, and the block stays IDLE.
- start while busy is ignored: no restart, no illegal.
- The cycle after an accepted start is M2T1 (mcyc=2, tcyc=0).
- tcyc increments every cycle. It wraps 3->0 and increments mcyc.
- LOAD_IMM:
  - M2 and M3: adr_sel=PC, rd=1 for all four T-states.
  - z_we (M2) / w_we (M3) is asserted at T3.
  - pc_inc is asserted at T4.
  - M3T4: rr_we=1 together with done=1.
  - Total 3 M-cycles.
  - For rr_sel=3 the destination is SP.
- SP_HL:
  - M2: adr_sel=HL, with no rd, no wr and no pc_inc (PC stable during M2).
  - M2T4: sp_from_hl=1 and done=1.
  - GP registers are never written.
  - Total 2 M-cycles.
- STORE_SP:
  - M2/M3: as LOAD_IMM (Z, then W, from PC with pc_inc at T4), but with no rr_we.
  - M4: adr_sel=WZ, wr=1 for T2..T4, dout_hi=0, wz_inc at T4.
  - M5: adr_sel=WZ, wr=1 for T2..T4, dout_hi=1.
  - M5T4: done=1.
  - Total 5 M-cycles.
- After done, the next cycle is IDLE with adr_sel=PC.
- A start in the same cycle as done is accepted, giving back-to-back instructions.
- rr_we, sp_from_hl, z_we and w_we are never asserted outside the slots listed above.
- rd and wr are never asserted together.

Test Plan:
- LD SP,HL (start, opcode=F9):
  - done at M2T4.
  - sp_from_hl exactly one cycle, at M2T4.
  - pc_inc, rd, wr and rr_we stay 0 throughout.
  - adr_sel=2 during M2.
  - busy high for 4 cycles.
- LD DE,nn (opcode=11):
  - z_we at M2T3, w_we at M3T3.
  - pc_inc at M2T4 and M3T4.
  - rr_we with rr_sel=1 at M3T4, coinciding with done.
  - busy for 8 cycles.
- LD (nn),SP (opcode=08):
  - wr for 3 cycles in M4 (dout_hi=0) and 3 cycles in M5 (dout_hi=1).
  - wz_inc at M4T4.
  - done at M5T4, 16 busy cycles.
  - rr_we never asserted.
- opcode=C3 with start -> illegal one cycle, busy stays 0, all strobes 0.
- Busy and reset cases:
  - start (opcode=01) during a LD (nn),SP sequence -> ignored; sequence timing unchanged.
  - reset_n=0 at M3T2 of LD HL,nn -> next cycle idle, and rr_we never asserted.
- start with opcode=F9 in the done cycle of LD BC,nn -> next cycle is M2T1 of the SP_HL sequence.
